// File: rtl/spi_ram_pkg.sv
// Shared types and defaults for the SPI-attached byte RAM.
// Command encoding, TX hold FSM states and default sizing.
package spi_ram_pkg;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic {
        TX_ST_IDLE = 1'b0,
        TX_ST_HOLD = 1'b1
    } tx_state_e;

    localparam int TX_HOLD_DEF   = 9;
    localparam int MEM_DEPTH_DEF = 256;
    localparam int ADDR_SIZE_DEF = 8;

endpackage

// File: rtl/spi_ram_mem.sv
// Byte storage: one sync write port, one sync read port with a
// registered, clearable output; write-first on address collision.
module spi_ram_mem #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    input  logic          clr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;
    logic [7:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (clr) begin
            rdata_d = '0;
        end else if (re) begin
            rdata_d = (we && (waddr == raddr)) ? wdata : mem_q[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram.sv
// Command decoder and TX hold timer between the SPI slave and its RAM.
// Define SPI_RAM_AUTOINC_EN to auto-increment addresses after data commands.
module spi_ram
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int TX_HOLD   = TX_HOLD_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       seq_err
);

    localparam int CNT_W = $clog2(TX_HOLD + 1);
    localparam int AW1   = ADDR_SIZE + 1;
    localparam logic [AW1-1:0] DEPTH_L = AW1'(MEM_DEPTH);

    logic                 rx_valid_q, rx_valid_d;
    logic                 cmd_vld_q, cmd_vld_d;
    cmd_e                 cmd_q, cmd_d;
    logic [7:0]           pay_q, pay_d;
    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic                 wr_vld_q, wr_vld_d;
    logic                 rd_vld_q, rd_vld_d;
    logic                 seq_err_q, seq_err_d;
    tx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic mem_we, mem_re, rd_go, rd_zero;

    function automatic logic in_range(input logic [ADDR_SIZE-1:0] a);
        return {1'b0, a} < DEPTH_L;
    endfunction

`ifdef SPI_RAM_AUTOINC_EN
    localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(MEM_DEPTH - 1);

    function automatic logic [ADDR_SIZE-1:0] inc(input logic [ADDR_SIZE-1:0] a);
        return (a == LAST) ? '0 : a + ADDR_SIZE'(1);
    endfunction
`endif

    always_comb begin
        rx_valid_d = rx_valid;
        cmd_vld_d  = rx_valid & ~rx_valid_q;
        cmd_d      = cmd_vld_d ? cmd_e'(din[9:8]) : cmd_q;
        pay_d      = cmd_vld_d ? din[7:0] : pay_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        wr_vld_d   = wr_vld_q;
        rd_vld_d   = rd_vld_q;
        seq_err_d  = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        rd_go      = 1'b0;
        rd_zero    = 1'b0;

        // commands act one cycle after their accept edge
        if (cmd_vld_q && rst_n) begin
            unique case (cmd_q)
                CMD_WR_ADDR: begin
                    wr_addr_d = ADDR_SIZE'(pay_q);
                    wr_vld_d  = 1'b1;
                end
                CMD_WR_DATA: begin
                    if (wr_vld_q) begin
                        mem_we = in_range(wr_addr_q);
`ifdef SPI_RAM_AUTOINC_EN
                        wr_addr_d = inc(wr_addr_q);
`endif
                    end else begin
                        seq_err_d = 1'b1;
                    end
                end
                CMD_RD_ADDR: begin
                    rd_addr_d = ADDR_SIZE'(pay_q);
                    rd_vld_d  = 1'b1;
                end
                CMD_RD_DATA: begin
                    if (rd_vld_q) begin
                        rd_go   = 1'b1;
                        mem_re  = in_range(rd_addr_q);
                        rd_zero = ~in_range(rd_addr_q);
`ifdef SPI_RAM_AUTOINC_EN
                        rd_addr_d = inc(rd_addr_q);
`else
                        rd_vld_d  = 1'b0;
`endif
                    end else begin
                        seq_err_d = 1'b1;
                    end
                end
            endcase
        end

        if (rd_go) begin
            state_d = TX_ST_HOLD;
            cnt_d   = CNT_W'(TX_HOLD);
        end else if (cmd_vld_q) begin
            state_d = TX_ST_IDLE;
            cnt_d   = '0;
        end else if (state_q == TX_ST_HOLD) begin
            if (cnt_q == CNT_W'(1)) begin
                state_d = TX_ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_valid_q <= 1'b0;
            cmd_vld_q  <= 1'b0;
            cmd_q      <= CMD_WR_ADDR;
            pay_q      <= '0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            wr_vld_q   <= 1'b0;
            rd_vld_q   <= 1'b0;
            seq_err_q  <= 1'b0;
            state_q    <= TX_ST_IDLE;
            cnt_q      <= '0;
        end else begin
            rx_valid_q <= rx_valid_d;
            cmd_vld_q  <= cmd_vld_d;
            cmd_q      <= cmd_d;
            pay_q      <= pay_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            wr_vld_q   <= wr_vld_d;
            rd_vld_q   <= rd_vld_d;
            seq_err_q  <= seq_err_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
        end
    end

    spi_ram_mem #(
        .DEPTH(MEM_DEPTH),
        .AW   (ADDR_SIZE)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .waddr(wr_addr_q),
        .wdata(pay_q),
        .re   (mem_re),
        .raddr(rd_addr_q),
        .clr  (~rst_n | rd_zero),
        .rdata(dout)
    );

    assign tx_valid = (state_q == TX_ST_HOLD);
    assign seq_err  = seq_err_q;

endmodule

// File: tb/tb_spi_ram.sv
// Scoreboard bench for spi_ram against a command-level reference model.
// Honors SPI_RAM_AUTOINC_EN in the model when the macro is defined.
module tb_spi_ram;

    localparam int HOLD = 9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] din = '0;
    logic       rx_valid = 1'b0;
    logic [7:0] dout;
    logic       tx_valid;
    logic       seq_err;

    spi_ram dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (din),
        .rx_valid(rx_valid),
        .dout    (dout),
        .tx_valid(tx_valid),
        .seq_err (seq_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // command-level model of the RAM and its sequencing rules
    typedef struct {
        int data;
        int len;
    } rd_t;

    int  m_mem [256];
    int  m_wa = 0;
    int  m_ra = 0;
    bit  m_wv = 0;
    bit  m_rv = 0;
    rd_t rd_q [$];
    int  se_q [$];

    function automatic void model_cmd(input int c, input int p, input int n,
                                      output bit rd, output int data);
        rd = 0;
        data = 0;
        case (c)
            0: begin
                m_wa = p;
                m_wv = 1;
            end
            1: begin
                if (m_wv) begin
                    m_mem[m_wa] = p;
`ifdef SPI_RAM_AUTOINC_EN
                    m_wa = (m_wa + 1) % 256;
`endif
                end else begin
                    se_q.push_back(n + 1);
                end
            end
            2: begin
                m_ra = p;
                m_rv = 1;
            end
            default: begin
                if (m_rv) begin
                    rd = 1;
                    data = m_mem[m_ra];
`ifdef SPI_RAM_AUTOINC_EN
                    m_ra = (m_ra + 1) % 256;
`else
                    m_rv = 0;
`endif
                end else begin
                    se_q.push_back(n + 1);
                end
            end
        endcase
    endfunction

    task automatic send(input int c, input int p, input int hold,
                        output bit rd, output int data, output int n);
        din = {c[1:0], p[7:0]};
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        n = cyc;
        model_cmd(c, p, n, rd, data);
        repeat (hold) @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic cmd(input int c, input int p, input int hold = 1);
        bit rd;
        int data;
        int n;
        send(c, p, hold, rd, data, n);
        if (rd) begin
            rd_q.push_back('{data, HOLD});
            repeat (HOLD + 2) @(negedge clk);
        end
    endtask

    task automatic model_reset();
        m_wv = 0;
        m_rv = 0;
        m_wa = 0;
        m_ra = 0;
    endtask

    // monitor: pops expectations whenever the DUT presents a response
    bit prev_tv = 0;
    int run = 0;
    int cap = 0;
    bit stable = 1;
    int exp_c;
    rd_t e;

    always @(negedge clk) begin
        while (se_q.size() != 0 && se_q[0] < cyc) begin
            check("seq_err_missing", cyc, se_q.pop_front());
        end
        if (seq_err) begin
            exp_c = (se_q.size() != 0) ? se_q.pop_front() : -1;
            check("seq_err_cycle", cyc, exp_c);
        end
        if (tx_valid && !prev_tv) begin
            run = 1;
            cap = int'(dout);
            stable = 1;
        end else if (tx_valid) begin
            run++;
            if (int'(dout) != cap) stable = 0;
        end else if (prev_tv) begin
            e = (rd_q.size() != 0) ? rd_q.pop_front() : '{-1, -1};
            check("rd_data", cap, e.data);
            check("rd_len", run, e.len);
            check("rd_stable", int'(stable), 1);
        end
        prev_tv = tx_valid;
    end

    initial begin
        bit rd;
        int data;
        int n;

        repeat (3) @(negedge clk);
        check("rst_dout", int'(dout), 0);
        check("rst_tx_valid", int'(tx_valid), 0);
        check("rst_seq_err", int'(seq_err), 0);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);

        for (int a = 0; a < 256; a++) begin
            cmd(0, a);
            cmd(1, int'($urandom_range(0, 255)));
        end

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);

        // illegal data commands straight out of reset
        cmd(1, 8'h11);
        cmd(3, 0);
        cmd(2, 8'h00);
        cmd(3, 0);

        cmd(0, 8'h3C);
        cmd(1, 8'hA5);
        cmd(2, 8'h3C);
        cmd(3, 0);
        cmd(3, 0);

        // held rx_valid must act exactly once
        cmd(0, 8'h10);
        cmd(1, 8'h55);
        cmd(0, 8'h10);
        cmd(1, 8'h77, 5);
        cmd(2, 8'h10);
        cmd(3, 0, 5);
        model_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cmd(1, 8'h22, 5);

        cmd(0, 8'hFF);
        cmd(1, 8'h01);
        cmd(1, 8'h02);
        cmd(2, 8'hFF);
        cmd(3, 0);
        cmd(3, 0);

        // WR_ADDR during a hold cuts tx_valid short
        cmd(2, 8'h3C);
        send(3, 0, 1, rd, data, n);
        rd_q.push_back('{data, 4});
        repeat (2) @(negedge clk);
        cmd(0, 8'h40);
        repeat (HOLD + 2) @(negedge clk);

        // reset four cycles into a hold
        cmd(2, 8'h10);
        send(3, 0, 1, rd, data, n);
        rd_q.push_back('{data, 4});
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_tx_valid", int'(tx_valid), 0);
        check("midrst_dout", int'(dout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        cmd(3, 0);

        for (int i = 0; i < 300; i++) begin
            cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                int'($urandom_range(1, 3)));
        end

        repeat (20) @(negedge clk);
        check("rd_q_drained", rd_q.size(), 0);
        check("se_q_drained", se_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
